// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Run controller around a programmable WIDTH-bit serial pattern
//            detector with bit-error tolerance, overlap mode, target count
//            and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8,
    parameter int TO_W  = 16,
    parameter int TOL_W = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [WIDTH-1:0] i_cfg_pattern,
    input  logic [TOL_W-1:0] i_cfg_tol,
    input  logic             i_cfg_overlap,
    input  logic [CNT_W-1:0] i_cfg_target,
    input  logic [TO_W-1:0]  i_cfg_timeout,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_data_valid,
    input  logic             i_data,
    output logic             o_busy,
    output logic             o_pattern_found,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_done,
    output logic             o_timeout
);

    localparam int               c_FILL_W  = $clog2(WIDTH + 1);
    localparam logic [5:0]       c_DEF6    = 6'b101001;
    localparam logic [WIDTH-1:0] c_DEF_PAT = WIDTH'(c_DEF6);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_seq;
    logic [c_FILL_W-1:0] r_fill;
    logic [TO_W-1:0]     r_timer;
    logic [WIDTH-1:0]    r_pattern;
    logic [TOL_W-1:0]    r_tol;
    logic                r_overlap;
    logic [CNT_W-1:0]    r_target;
    logic [TO_W-1:0]     r_timeout_cfg;
    logic                r_cfg_ready;
    logic                r_busy;
    logic                r_found;
    logic [CNT_W-1:0]    r_match_cnt;
    logic                r_done;
    logic                r_timeout;

    logic [WIDTH-1:0]    w_seq_next;
    logic [WIDTH-1:0]    w_diff;
    logic [TOL_W-1:0]    w_errs;
    logic                w_active;
    logic                w_full;
    logic                w_hit;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_tgt_hit;
    logic                w_to_hit;

    // The window is full either in RUN or on the WIDTH-th fresh bit in ARM.
    always_comb begin
        w_seq_next = {r_seq[WIDTH-2:0], i_data};
        w_diff     = w_seq_next ^ r_pattern;
        w_errs     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_errs = w_errs + TOL_W'(w_diff[i]);
        end
        w_active  = (r_state == S_ARM) || (r_state == S_RUN);
        w_full    = (r_state == S_RUN) || (r_fill == c_FILL_W'(WIDTH - 1));
        w_hit     = w_active && i_data_valid && w_full && (w_errs <= r_tol);
        w_cnt_inc = (r_match_cnt == c_CNT_MAX) ? r_match_cnt
                                               : r_match_cnt + CNT_W'(1);
        w_tgt_hit = (r_target != '0) && (w_cnt_inc == r_target);
        w_to_hit  = (r_timeout_cfg != '0) &&
                    (r_timer == r_timeout_cfg - TO_W'(1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_seq         <= '0;
            r_fill        <= '0;
            r_timer       <= '0;
            r_pattern     <= c_DEF_PAT;
            r_tol         <= '0;
            r_overlap     <= 1'b1;
            r_target      <= '0;
            r_timeout_cfg <= '0;
            r_cfg_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_found       <= 1'b0;
            r_match_cnt   <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_found <= 1'b0;
            if (i_abort) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_cfg_ready <= 1'b1;
                r_done      <= 1'b0;
                r_timeout   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (i_cfg_valid) begin
                            r_pattern     <= i_cfg_pattern;
                            r_tol         <= i_cfg_tol;
                            r_overlap     <= i_cfg_overlap;
                            r_target      <= i_cfg_target;
                            r_timeout_cfg <= i_cfg_timeout;
                        end
                        if (i_start) begin
                            r_state     <= S_ARM;
                            r_busy      <= 1'b1;
                            r_cfg_ready <= 1'b0;
                            r_match_cnt <= '0;
                            r_fill      <= '0;
                            r_timer     <= '0;
                            r_seq       <= '0;
                            r_done      <= 1'b0;
                            r_timeout   <= 1'b0;
                        end
                    end
                    S_ARM, S_RUN: begin
                        r_timer <= r_timer + TO_W'(1);
                        if (i_data_valid) begin
                            r_seq <= w_seq_next;
                            if (r_state == S_ARM) begin
                                r_fill <= r_fill + c_FILL_W'(1);
                                if (w_full) begin
                                    r_state <= S_RUN;
                                end
                            end
                        end
                        if (w_hit) begin
                            r_found     <= 1'b1;
                            r_match_cnt <= w_cnt_inc;
                            if (!r_overlap) begin
                                r_fill  <= '0;
                                r_state <= S_ARM;
                            end
                        end
                        // A target-reaching match outranks a same-cycle timeout.
                        if (w_hit && w_tgt_hit) begin
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_cfg_ready <= 1'b1;
                            r_done      <= 1'b1;
                            r_timeout   <= 1'b0;
                        end else if (w_to_hit) begin
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_cfg_ready <= 1'b1;
                            r_done      <= 1'b1;
                            r_timeout   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_cfg_ready     = r_cfg_ready;
    assign o_busy          = r_busy;
    assign o_pattern_found = r_found;
    assign o_match_cnt     = r_match_cnt;
    assign o_done          = r_done;
    assign o_timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Purpose  : Self-checking bench for seq_detect_ctrl against a bit-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    localparam int WIDTH = 6;
    localparam int CNT_W = 8;
    localparam int TO_W  = 16;
    localparam int TOL_W = 3;
    localparam int VW    = CNT_W + 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [VW-1:0] RST_V = {1'b0, 1'b0, {CNT_W{1'b0}}, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_reset = 1'b0, i_cfg_valid = 1'b0, i_cfg_overlap = 1'b0;
    logic [WIDTH-1:0] i_cfg_pattern = '0;
    logic [TOL_W-1:0] i_cfg_tol = '0;
    logic [CNT_W-1:0] i_cfg_target = '0;
    logic [TO_W-1:0]  i_cfg_timeout = '0;
    logic             i_start = 1'b0, i_abort = 1'b0, i_data_valid = 1'b0, i_data = 1'b0;
    logic             o_cfg_ready, o_busy, o_pattern_found, o_done, o_timeout;
    logic [CNT_W-1:0] o_match_cnt;
    logic [VW-1:0]    dvec;

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TO_W(TO_W), .TOL_W(TOL_W)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_pattern(i_cfg_pattern), .i_cfg_tol(i_cfg_tol), .i_cfg_overlap(i_cfg_overlap),
        .i_cfg_target(i_cfg_target), .i_cfg_timeout(i_cfg_timeout), .i_start(i_start),
        .i_abort(i_abort), .i_data_valid(i_data_valid), .i_data(i_data), .o_busy(o_busy),
        .o_pattern_found(o_pattern_found), .o_match_cnt(o_match_cnt), .o_done(o_done),
        .o_timeout(o_timeout)
    );

    assign dvec = {o_busy, o_pattern_found, o_match_cnt, o_done, o_timeout, o_cfg_ready};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: run flag, list of received bits, fresh-bit count, elapsed cycles.
    bit             m_busy, m_found, m_done, m_to, m_ready, m_ovl;
    int             m_cnt, m_tol, m_target, m_timeout, m_fresh, m_elapsed;
    logic [WIDTH-1:0] m_pat;
    int             m_win[$];

    int s1[11] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
    int s3[6]  = '{1, 0, 1, 0, 1, 1};

    function automatic logic [VW-1:0] mvec();
        return {m_busy, m_found, CNT_W'(m_cnt), m_done, m_to, m_ready};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_found = 0; m_done = 0; m_to = 0; m_ready = 1; m_cnt = 0;
        m_pat = 6'b101001; m_tol = 0; m_ovl = 1; m_target = 0; m_timeout = 0;
        m_win.delete(); m_fresh = 0; m_elapsed = 0;
    endtask

    task automatic model_finish(input bit by_timeout);
        m_busy = 0; m_ready = 1; m_done = 1; m_to = by_timeout;
    endtask

    task automatic model_edge(input bit rst, input bit cv, input bit st, input bit ab,
                              input bit dv, input bit d);
        bit hit;
        bit timed_out;
        int errs;
        m_found = 0;
        if (rst) begin model_reset(); return; end
        if (ab) begin m_busy = 0; m_done = 0; m_to = 0; m_ready = 1; return; end
        if (!m_busy) begin
            if (cv) begin
                m_pat = i_cfg_pattern; m_tol = int'(i_cfg_tol); m_ovl = i_cfg_overlap;
                m_target = int'(i_cfg_target); m_timeout = int'(i_cfg_timeout);
            end
            if (st) begin
                m_busy = 1; m_ready = 0; m_cnt = 0; m_done = 0; m_to = 0;
                m_win.delete(); m_fresh = 0; m_elapsed = 0;
            end
            return;
        end
        hit = 0;
        if (dv) begin
            m_win.push_back(int'(d));
            if (m_win.size() > WIDTH) void'(m_win.pop_front());
            m_fresh++;
            if (m_fresh >= WIDTH) begin
                errs = 0;
                for (int k = 0; k < WIDTH; k++)
                    if (m_win[k] != int'(m_pat[WIDTH-1-k])) errs++;
                hit = (errs <= m_tol);
            end
        end
        timed_out = (m_timeout != 0) && (m_elapsed == m_timeout - 1);
        m_elapsed++;
        if (hit) begin
            m_found = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_target != 0 && m_cnt == m_target) begin model_finish(0); return; end
            if (!m_ovl) m_fresh = 0;
        end
        if (timed_out) model_finish(1);
    endtask

    task automatic step(input bit rst, input bit cv, input bit st, input bit ab,
                        input bit dv, input bit d);
        i_reset = rst; i_cfg_valid = cv; i_start = st; i_abort = ab;
        i_data_valid = dv; i_data = d;
        model_edge(rst, cv, st, ab, dv, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_cfg(input logic [WIDTH-1:0] pat, input int tol, input bit ovl,
                           input int target, input int timeout);
        i_cfg_pattern = pat; i_cfg_tol = TOL_W'(tol); i_cfg_overlap = ovl;
        i_cfg_target = CNT_W'(target); i_cfg_timeout = TO_W'(timeout);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (dvec !== RST_V) begin
            errors++; $display("FAIL reset_outputs got %h want %h", dvec, RST_V);
        end
        step(0, 0, 0, 0, 1, 1);
        checks++;
        if (dvec !== mvec()) begin
            errors++; $display("FAIL reset_idle got %h want %h", dvec, mvec());
        end
    endtask

    task automatic test_target();
        int pulses = 0;
        set_cfg(6'b101001, 0, 1, 2, 0);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 0, 0, 1, 1'(s1[i]));
            checks++;
            if (dvec !== mvec() || o_pattern_found !== (i == 5 || i == 10)) begin
                errors++; $display("FAIL target bit%0d got %h want %h", i + 1, dvec, mvec());
            end
            if (o_pattern_found) pulses++;
        end
        step(0, 0, 0, 0, 1, 0);
        checks++;
        if (pulses != 2 || o_match_cnt !== 8'd2 || o_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL target_end got pulses=%0d cnt=%0d done=%b busy=%b want 2/2/1/0",
                     pulses, o_match_cnt, o_done, o_busy);
        end
    endtask

    task automatic test_overlap0();
        int pulses = 0;
        set_cfg(6'b101001, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 0, 0, 1, 1'(s1[i]));
            checks++;
            if (dvec !== mvec() || o_pattern_found !== (i == 5)) begin
                errors++; $display("FAIL overlap0 bit%0d got %h want %h", i + 1, dvec, mvec());
            end
            if (o_pattern_found) pulses++;
        end
        checks++;
        if (pulses != 1 || o_match_cnt !== 8'd1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL overlap0_end got pulses=%0d cnt=%0d busy=%b done=%b want 1/1/1/0",
                     pulses, o_match_cnt, o_busy, o_done);
        end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_tolerance();
        for (int t = 0; t < 2; t++) begin
            int pulses = 0;
            set_cfg(6'b101001, t, 1, 0, 0);
            step(0, 1, 1, 0, 0, 0);
            for (int i = 0; i < 6; i++) begin
                step(0, 0, 0, 0, 1, 1'(s3[i]));
                checks++;
                if (dvec !== mvec()) begin
                    errors++; $display("FAIL tol%0d bit%0d got %h want %h", t, i + 1, dvec, mvec());
                end
                if (o_pattern_found) pulses++;
            end
            checks++;
            if (pulses != t || o_match_cnt !== CNT_W'(t)) begin
                errors++;
                $display("FAIL tol%0d_end got pulses=%0d cnt=%0d want %0d", t, pulses, o_match_cnt, t);
            end
            step(0, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_timeout();
        int busy_cycles = 0;
        set_cfg(6'b101001, 0, 1, 1, 20);
        step(0, 1, 1, 0, 0, 0);
        if (o_busy) busy_cycles++;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, 1, 0);
            checks++;
            if (dvec !== mvec()) begin
                errors++; $display("FAIL timeout cyc%0d got %h want %h", i, dvec, mvec());
            end
            if (o_busy) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 20 || o_done !== 1'b1 || o_timeout !== 1'b1 || o_match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL timeout_end got busy=%0d done=%b to=%b cnt=%0d want 20/1/1/0",
                     busy_cycles, o_done, o_timeout, o_match_cnt);
        end
        // Completing bit lands on the last permitted cycle: match must win.
        set_cfg(6'b101001, 0, 1, 1, 6);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1'(s1[i]));
        checks++;
        if (o_pattern_found !== 1'b1 || o_done !== 1'b1 || o_timeout !== 1'b0 || o_match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL timeout_tie got found=%b done=%b to=%b cnt=%0d want 1/1/0/1",
                     o_pattern_found, o_done, o_timeout, o_match_cnt);
        end
    endtask

    task automatic test_cfg_busy_abort();
        int tail[4] = '{0, 1, 0, 0};
        set_cfg(6'b101001, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1'(s1[i]));
        checks++;
        if (o_cfg_ready !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL busy_ready got ready=%b busy=%b want 0/1", o_cfg_ready, o_busy);
        end
        set_cfg(6'b111111, 0, 1, 1, 0);
        for (int i = 6; i < 11; i++) begin
            step(0, i == 6, 0, 0, 1, 1'(s1[i]));
            checks++;
            if (dvec !== mvec()) begin
                errors++; $display("FAIL cfg_ignored bit%0d got %h want %h", i + 1, dvec, mvec());
            end
        end
        checks++;
        if (o_match_cnt !== 8'd2 || o_busy !== 1'b1) begin
            errors++; $display("FAIL cfg_ignored_end got cnt=%0d busy=%b want 2/1", o_match_cnt, o_busy);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1'(tail[i]));
        step(0, 0, 0, 1, 1, 1);
        checks++;
        if (o_busy !== 1'b0 || o_match_cnt !== 8'd2 || o_cfg_ready !== 1'b1 ||
            o_done !== 1'b0 || o_pattern_found !== 1'b0 || dvec !== mvec()) begin
            errors++;
            $display("FAIL abort got busy=%b cnt=%0d ready=%b done=%b found=%b want 0/2/1/0/0",
                     o_busy, o_match_cnt, o_cfg_ready, o_done, o_pattern_found);
        end
    endtask

    task automatic test_gaps();
        logic [WIDTH-1:0] pat = 6'b101001;
        set_cfg(pat, 0, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < WIDTH; i++) begin
            int gap = int'($urandom_range(1, 2));
            for (int g = 0; g < gap; g++) begin
                step(0, 0, 0, 0, 0, 1'($urandom));
                checks++;
                if (dvec !== mvec() || o_pattern_found !== 1'b0) begin
                    errors++; $display("FAIL gaps idle%0d got %h want %h", i, dvec, mvec());
                end
            end
            step(0, 0, 0, 0, 1, pat[WIDTH-1-i]);
        end
        checks++;
        if (o_pattern_found !== 1'b1 || o_done !== 1'b1 || o_match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL gaps_match got found=%b done=%b cnt=%0d want 1/1/1",
                     o_pattern_found, o_done, o_match_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        set_cfg(6'b111000, 2, 0, 3, 50);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 1'($urandom));
        step(1, 0, 0, 0, 1, 1);
        checks++;
        if (dvec !== RST_V) begin
            errors++; $display("FAIL reset_midrun got %h want %h", dvec, RST_V);
        end
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1'(s1[i]));
        checks++;
        if (o_pattern_found !== 1'b1 || o_busy !== 1'b1 || dvec !== mvec()) begin
            errors++;
            $display("FAIL reset_default_pat got %h want %h", dvec, mvec());
        end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_saturate();
        set_cfg(6'b000000, WIDTH, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 270; i++) begin
            step(0, 0, 0, 0, 1, 1'($urandom));
            checks++;
            if (dvec !== mvec()) begin
                errors++; $display("FAIL saturate bit%0d got %h want %h", i + 1, dvec, mvec());
            end
        end
        checks++;
        if (o_match_cnt !== 8'hFF || o_busy !== 1'b1) begin
            errors++; $display("FAIL saturate_end got cnt=%0d busy=%b want 255/1", o_match_cnt, o_busy);
        end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bit cv = ($urandom_range(0, 3) == 0);
            if (cv) begin
                set_cfg(WIDTH'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                        int'($urandom_range(0, 5)),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 80)) : 0);
            end
            step($urandom_range(0, 299) == 0, cv, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
            checks++;
            if (dvec !== mvec()) begin
                errors++; $display("FAIL random cyc%0d got %h want %h", cyc, dvec, mvec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_target();
        test_overlap0();
        test_tolerance();
        test_timeout();
        test_cfg_busy_abort();
        test_gaps();
        test_reset_midrun();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
